// File: rtl/seg7_scan_ctrl.sv
// Four-digit time-multiplexed scan controller for a common-anode 7-segment display.
// Every output is registered, computed from the next-state values so each output tracks the current state.
module seg7_scan_ctrl #(
  parameter int TICK_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  dig_mask,
  input  logic        lz_blank,
  input  logic [3:0]  dp_in,
  output logic [3:0]  bin,
  output logic [3:0]  an,
  output logic        dp,
  output logic        blank,
  output logic [1:0]  slot,
  output logic        frame_done
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(TICK_DIV - BLANK_CYC - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t        state, state_nx;
  logic [1:0]    slot_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          latch, fd_nx;
  logic [15:0]   dig_lat, dig_nx;
  logic [3:0]    mask_lat, mask_nx, dp_lat, dp_nx;
  logic          lz_lat, lz_nx;
  logic [3:0]    sup_nx, an_nx, bin_nx;
  logic          dp_o_nx, blank_nx, zero_run;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      slot       <= 2'd0;
      cnt        <= '0;
      dig_lat    <= 16'h0;
      mask_lat   <= 4'h0;
      dp_lat     <= 4'h0;
      lz_lat     <= 1'b0;
      an         <= 4'b1111;
      bin        <= 4'h0;
      dp         <= 1'b1;
      blank      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      slot       <= slot_nx;
      cnt        <= cnt_nx;
      dig_lat    <= dig_nx;
      mask_lat   <= mask_nx;
      dp_lat     <= dp_nx;
      lz_lat     <= lz_nx;
      an         <= an_nx;
      bin        <= bin_nx;
      dp         <= dp_o_nx;
      blank      <= blank_nx;
      frame_done <= fd_nx;
    end
  end

  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    cnt_nx   = cnt;
    latch    = 1'b0;
    fd_nx    = 1'b0;
    an_nx    = 4'b1111;
    bin_nx   = 4'h0;
    dp_o_nx  = 1'b1;
    blank_nx = 1'b1;
    zero_run = 1'b1;
    sup_nx   = 4'h0;

    case (state)
      IDLE: begin
        if (en) begin
          state_nx = BLANK;
          slot_nx  = 2'd0;
          cnt_nx   = '0;
          latch    = 1'b1;
        end
      end
      BLANK, SHOW: begin
        if (!en) begin
          state_nx = IDLE;
          slot_nx  = 2'd0;
          cnt_nx   = '0;
        end else if (state == BLANK) begin
          if (cnt == BLANK_LAST) begin
            state_nx = SHOW;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end else if (cnt == SHOW_LAST) begin
          state_nx = BLANK;
          slot_nx  = slot + 2'd1;
          cnt_nx   = '0;
          // Frame boundary: capture a fresh snapshot so a frame never tears.
          if (slot == 2'd3) begin
            latch = 1'b1;
            fd_nx = 1'b1;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        slot_nx  = 2'd0;
        cnt_nx   = '0;
      end
    endcase

    dig_nx  = latch ? digits   : dig_lat;
    mask_nx = latch ? dig_mask : mask_lat;
    dp_nx   = latch ? dp_in    : dp_lat;
    lz_nx   = latch ? lz_blank : lz_lat;

    // Walk from the top digit down; a digit is a leading zero while every digit above it is zero too.
    for (int i = 3; i >= 0; i--) begin
      zero_run  = zero_run & (dig_nx[i*4 +: 4] == 4'h0);
      sup_nx[i] = ~mask_nx[i] | (lz_nx & (i > 0) & zero_run);
    end

    if (state_nx != IDLE) begin
      bin_nx = dig_nx[{slot_nx, 2'b00} +: 4];
      if (state_nx == SHOW && !sup_nx[slot_nx]) begin
        an_nx[slot_nx] = 1'b0;
        blank_nx       = 1'b0;
        dp_o_nx        = ~dp_nx[slot_nx];
      end
    end
  end

endmodule
